// File: rtl/pb_flag_ctrl.sv
// Purpose: synchronise/debounce two active-low pushbuttons into sticky request flags, optional PB0 auto-repeat (PB_AUTOREPEAT_EN).
// Latency: level follows raw input 1+DEBOUNCE_CYCLES edges after stage-1 capture; flag sets one edge after level rises.
// Backpressure: a flag holds until its read strobe; an event arriving on an unread set flag is dropped and reported on event_drop.
module pb_flag_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES     = 500_000,
    parameter int unsigned REPEAT_DELAY_CYCLES = 25_000_000,
    parameter int unsigned REPEAT_RATE_CYCLES  = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PB0_n,
    input  logic       PB1_n,
    input  logic       PB0_read,
    input  logic       PB1_read,
    output logic       PB0_flag,
    output logic       PB1_flag,
    output logic       pb0_level,
    output logic       pb1_level,
    output logic [1:0] event_drop
);

    // Terminal count of the debounce counter: level flips on the Nth consecutive mismatching cycle.
    localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  raw_pressed;
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  level;
    logic [1:0]  level_q;
    logic [31:0] db_cnt [2];
    logic [1:0]  press;
    logic [1:0]  evt;
    logic [1:0]  read;
    logic [1:0]  flag;
    logic [1:0]  drop;
    logic        rep_evt;

    // Buttons are active-low; invert before the synchroniser so the reset value 0 means "not pressed".
    assign raw_pressed = {~PB1_n, ~PB0_n};
    assign read        = {PB1_read, PB0_read};

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_pressed;
            sync2 <= sync1;
        end
    end

    // Debounce: count consecutive cycles the synchronised input disagrees with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 32'd1;
                end
            end
        end
    end

    // Delayed level for rising-edge (press) detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level;
        end
    end

    // A press is the first cycle the accepted level is high; releases generate nothing.
    assign press = level & ~level_q;

`ifdef PB_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        HOLD     = 2'd1,
        REPEAT   = 2'd2
    } rep_state_t;

    localparam logic [31:0] DELAY_LAST = 32'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [31:0] RATE_LAST  = 32'(REPEAT_RATE_CYCLES - 1);

    rep_state_t  rep_state;
    rep_state_t  rep_state_nxt;
    logic [31:0] rep_cnt;
    logic [31:0] rep_cnt_nxt;

    // Auto-repeat state and hold-time counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_state <= RELEASED;
            rep_cnt   <= '0;
        end else begin
            rep_state <= rep_state_nxt;
            rep_cnt   <= rep_cnt_nxt;
        end
    end

    // Auto-repeat next state: a release always wins over a repeat due in the same cycle.
    always_comb begin
        rep_state_nxt = rep_state;
        rep_cnt_nxt   = rep_cnt;
        rep_evt       = 1'b0;
        case (rep_state)
            RELEASED: begin
                rep_cnt_nxt = '0;
                if (press[0]) begin
                    rep_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!level[0]) begin
                    rep_state_nxt = RELEASED;
                    rep_cnt_nxt   = '0;
                end else if (rep_cnt == DELAY_LAST) begin
                    rep_evt       = 1'b1;
                    rep_cnt_nxt   = '0;
                    rep_state_nxt = REPEAT;
                end else begin
                    rep_cnt_nxt = rep_cnt + 32'd1;
                end
            end
            REPEAT: begin
                if (!level[0]) begin
                    rep_state_nxt = RELEASED;
                    rep_cnt_nxt   = '0;
                end else if (rep_cnt == RATE_LAST) begin
                    rep_evt     = 1'b1;
                    rep_cnt_nxt = '0;
                end else begin
                    rep_cnt_nxt = rep_cnt + 32'd1;
                end
            end
            default: begin
                rep_state_nxt = RELEASED;
                rep_cnt_nxt   = '0;
            end
        endcase
    end
`else
    // Without auto-repeat PB0 behaves exactly like PB1; the repeat parameters are kept only for interface compatibility.
    logic [63:0] cfg_unused;
    assign cfg_unused = {32'(REPEAT_DELAY_CYCLES), 32'(REPEAT_RATE_CYCLES)};
    assign rep_evt    = 1'b0;
`endif

    // Repeat events are indistinguishable from presses downstream.
    assign evt = {press[1], press[0] | rep_evt};

    // Sticky flags: a new event beats a coincident read; an event onto an unread set flag is reported and lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag <= '0;
            drop <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                drop[i] <= evt[i] & flag[i] & ~read[i];
                if (evt[i]) begin
                    flag[i] <= 1'b1;
                end else if (read[i]) begin
                    flag[i] <= 1'b0;
                end
            end
        end
    end

    assign PB0_flag   = flag[0];
    assign PB1_flag   = flag[1];
    assign pb0_level  = level[0];
    assign pb1_level  = level[1];
    assign event_drop = drop;

endmodule

// File: tb/tb_pb_flag_ctrl.sv
// Purpose: self-checking bench for pb_flag_ctrl: scoreboard of per-cycle expected outputs plus directed timing checks.
// Latency: expected outputs are produced by a window-based reference model one entry per clock edge.
// Backpressure: read strobes are driven randomly or in response to observed flags.
module tb_pb_flag_ctrl;

    localparam int D    = 4;
    localparam int DLY  = 20;
    localparam int RATE = 8;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       PB0_n    = 1'b1;
    logic       PB1_n    = 1'b1;
    logic       PB0_read = 1'b0;
    logic       PB1_read = 1'b0;
    logic       PB0_flag;
    logic       PB1_flag;
    logic       pb0_level;
    logic       pb1_level;
    logic [1:0] event_drop;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pb_flag_ctrl #(
        .DEBOUNCE_CYCLES    (D),
        .REPEAT_DELAY_CYCLES(DLY),
        .REPEAT_RATE_CYCLES (RATE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PB0_n     (PB0_n),
        .PB1_n     (PB1_n),
        .PB0_read  (PB0_read),
        .PB1_read  (PB1_read),
        .PB0_flag  (PB0_flag),
        .PB1_flag  (PB1_flag),
        .pb0_level (pb0_level),
        .pb1_level (pb1_level),
        .event_drop(event_drop)
    );

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h at time %0t", name, act, exp, $time);
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       f0;
        logic       f1;
        logic       l0;
        logic       l1;
        logic [1:0] drop;
    } snap_t;

    snap_t  exp_q[$];
    bit     hist [2][0:D];   // last D+1 sampled pressed values, index D newest
    bit     m_lvl [2];
    bit     m_rose[2];
    bit     m_flag[2];
    bit [1:0] m_drop;
    longint edge_no  = 0;
    longint next_rep = -1;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k <= D; k++) hist[i][k] = 1'b0;
            m_lvl[i]  = 1'b0;
            m_rose[i] = 1'b0;
            m_flag[i] = 1'b0;
        end
        m_drop   = 2'b00;
        next_rep = -1;
    endfunction

    function automatic snap_t snap_now();
        snap_t s;
        s.f0   = m_flag[0];
        s.f1   = m_flag[1];
        s.l0   = m_lvl[0];
        s.l1   = m_lvl[1];
        s.drop = m_drop;
        return s;
    endfunction

    function automatic void model_step();
        bit ev[2];
        bit rd[2];
        bit cap[2];
        rd[0]  = PB0_read;
        rd[1]  = PB1_read;
        cap[0] = ~PB0_n;
        cap[1] = ~PB1_n;
        edge_no++;
        ev[0] = m_rose[0];
        ev[1] = m_rose[1];
`ifdef PB_AUTOREPEAT_EN
        // Repeats are scheduled in absolute edge numbers from the press; a released level cancels the schedule.
        if (m_rose[0]) begin
            next_rep = edge_no + DLY;
        end else if (next_rep >= 0) begin
            if (!m_lvl[0]) begin
                next_rep = -1;
            end else if (edge_no == next_rep) begin
                ev[0]    = 1'b1;
                next_rep = next_rep + RATE;
            end
        end
`endif
        for (int i = 0; i < 2; i++) begin
            m_drop[i] = ev[i] && m_flag[i] && !rd[i];
            if (ev[i]) m_flag[i] = 1'b1;
            else if (rd[i]) m_flag[i] = 1'b0;
        end
        // Level takes a new value once D consecutive samples (ending two edges ago) all disagree with it.
        for (int i = 0; i < 2; i++) begin
            bit all_flip;
            all_flip = 1'b1;
            for (int k = 0; k < D; k++) if (hist[i][k] == m_lvl[i]) all_flip = 1'b0;
            m_rose[i] = all_flip && !m_lvl[i];
            if (all_flip) m_lvl[i] = !m_lvl[i];
            for (int k = 0; k < D; k++) hist[i][k] = hist[i][k+1];
            hist[i][D] = cap[i];
        end
    endfunction

    // Model advances on every edge and pushes the outputs expected after it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
            exp_q.delete();
            exp_q.push_back(snap_now());
        end else begin
            model_step();
            exp_q.push_back(snap_now());
        end
    end

    // Monitor: compare DUT outputs against the scoreboard mid-cycle.
    always @(negedge clk) begin
        snap_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle_outputs",
                {2'b00, PB0_flag, PB1_flag, pb0_level, pb1_level, event_drop},
                {2'b00, e});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int cnt;
        int seen;
        int hold0;
        int hold1;
        int rst_hold;

        tick(3);
        chk("reset_outputs", {2'b00, PB0_flag, PB1_flag, pb0_level, pb1_level, event_drop}, 8'h00);
        rst_n = 1'b1;
        tick(2);

        // Clean press on PB0, consume at edge 10.
        PB0_n = 1'b0;
        tick(5);
        chk("press_level_edge4", 8'(pb0_level), 8'h00);
        tick(1);
        chk("press_level_edge5", 8'(pb0_level), 8'h01);
        chk("press_flag_edge5", 8'(PB0_flag), 8'h00);
        tick(1);
        chk("press_flag_edge6", 8'(PB0_flag), 8'h01);
        tick(3);
        PB0_read = 1'b1;
        tick(1);
        PB0_read = 1'b0;
        chk("read_clears_flag", 8'(PB0_flag), 8'h00);
        PB0_n = 1'b1;
        tick(10);

        // Bounce on PB1, then a stable low.
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            PB1_n = (((c / 2) % 2) != 0);
            tick(1);
            if (PB1_flag || pb1_level) seen++;
        end
        chk("bounce_no_flag", 8'(seen), 8'h00);
        PB1_n = 1'b0;
        tick(6);
        chk("bounce_flag_edge5", 8'(PB1_flag), 8'h00);
        tick(1);
        chk("bounce_flag_edge6", 8'(PB1_flag), 8'h01);

        // Overrun on PB1: second press with the flag still pending.
        PB1_n = 1'b1;
        tick(10);
        PB1_n = 1'b0;
        tick(6);
        chk("overrun_drop_before", 8'(event_drop), 8'h00);
        tick(1);
        chk("overrun_drop_pulse", 8'(event_drop), 8'h02);
        chk("overrun_flag_held", 8'(PB1_flag), 8'h01);
        tick(1);
        chk("overrun_drop_one_cycle", 8'(event_drop), 8'h00);
        PB1_read = 1'b1;
        tick(1);
        PB1_read = 1'b0;
        PB1_n = 1'b1;
        tick(10);

        // Read coincident with a new PB0 press event.
        PB0_n = 1'b0;
        tick(7);
        chk("coinc_setup_flag", 8'(PB0_flag), 8'h01);
        PB0_n = 1'b1;
        tick(10);
        PB0_n = 1'b0;
        tick(6);
        PB0_read = 1'b1;
        tick(1);
        PB0_read = 1'b0;
        chk("coinc_flag_kept", 8'(PB0_flag), 8'h01);
        chk("coinc_no_drop", 8'(event_drop), 8'h00);
        PB0_n = 1'b1;
        tick(1);
        PB0_read = 1'b1;
        tick(1);
        PB0_read = 1'b0;
        tick(10);

        // Hold PB0 for 60 cycles, consuming every flag as soon as it shows.
        cnt = 0;
        PB0_n = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (c == 60) PB0_n = 1'b1;
            tick(1);
            PB0_read = PB0_flag;
            if (PB0_flag) cnt++;
        end
        PB0_read = 1'b0;
`ifdef PB_AUTOREPEAT_EN
        chk("autorepeat_flag_count", 8'(cnt), 8'd6);
`else
        chk("autorepeat_flag_count", 8'(cnt), 8'd1);
`endif
        tick(2);

        // Reset while PB0 is held, then re-debounce across reset release.
        PB0_n = 1'b0;
        tick(40);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_hold", {2'b00, PB0_flag, PB1_flag, pb0_level, pb1_level, event_drop}, 8'h00);
        tick(3);
        rst_n = 1'b1;
        tick(6);
        chk("rerelease_level_edge5", 8'(pb0_level), 8'h01);
        chk("rerelease_flag_edge5", 8'(PB0_flag), 8'h00);
        tick(1);
        chk("rerelease_flag_edge6", 8'(PB0_flag), 8'h01);
        PB0_n = 1'b1;
        PB0_read = 1'b1;
        tick(1);
        PB0_read = 1'b0;
        tick(10);

        // Random phase: mixed bounces and long holds, random reads, rare resets.
        hold0    = 0;
        hold1    = 0;
        rst_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold0 == 0) begin
                PB0_n = ~PB0_n;
                hold0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(10, 45));
            end else begin
                hold0--;
            end
            if (hold1 == 0) begin
                PB1_n = ~PB1_n;
                hold1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(10, 45));
            end else begin
                hold1--;
            end
            PB0_read = ($urandom_range(0, 5) == 0);
            PB1_read = ($urandom_range(0, 5) == 0);
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 799) == 0) begin
                rst_n    = 1'b0;
                rst_hold = 2;
            end
            tick(1);
        end
        rst_n    = 1'b1;
        PB0_read = 1'b0;
        PB1_read = 1'b0;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pb_flag_ctrl.md
# pb_flag_ctrl

Pushbutton front-end controller for the countdown timer. It synchronizes and debounces the two raw active-low pushbuttons and turns presses into sticky request flags (`PB0_flag` increment/clear-to-increment, `PB1_flag` start/stop). Each flag holds until the timer consumes it with its one-cycle `PBx_read` pulse. An optional auto-repeat generates repeated increment requests while PB0 is held.

## Interface
- `DEBOUNCE_CYCLES`, default 500_000: consecutive stable cycles (10 ms at 50 MHz) needed to accept a level change; ≥1.
- `REPEAT_DELAY_CYCLES`, default 25_000_000: hold time from accepted PB0 press to first repeat event; ≥1.
- `REPEAT_RATE_CYCLES`, default 10_000_000: period between subsequent repeat events; ≥1.
- `clk` in 1: system clock; the single clock domain.
- `rst_n` in 1: reset, asynchronous and active-low.
- `PB0_n` in 1: raw PB0, active-low, asynchronous to `clk`.
- `PB1_n` in 1: raw PB1, active-low, asynchronous to `clk`.
- `PB0_read` in 1: timer consume strobe for `PB0_flag`.
- `PB1_read` in 1: timer consume strobe for `PB1_flag`.
- `PB0_flag` out 1: pending PB0 request.
- `PB1_flag` out 1: pending PB1 request.
- `pb0_level` out 1: debounced PB0 level, 1 = pressed.
- `pb1_level` out 1: debounced PB1 level, 1 = pressed.
- `event_drop` out 2: one-cycle pulse per button when an event arrives while its flag is already set and not being read. Bit 0 = PB0, bit 1 = PB1.

## Operation
- **Synchronizer and inversion:** each raw input passes through a 2-flop synchronizer and is inverted to active-high. This gives `s2`.
- **Debounce (per button):**
  - A 32-bit counter runs while `s2 != level`. Any cycle with `s2 == level` clears the counter to 0.
  - When the counter equals `DEBOUNCE_CYCLES-1` and the mismatch persists, `level <= s2` and the counter clears.
- **Press event:** the cycle after `level` rises 0→1. A release produces no event.
- **Flag update (per button), evaluated each edge:**
  - Event = 1: `flag <= 1`, whatever the state of read.
  - Else, read = 1: `flag <= 0`.
  - Else: hold.
  - Event while `flag = 1` and read = 0: `event_drop[i]` pulses for 1 cycle. The event is lost, never queued.
  - Read while `flag = 0`: ignored.
- **Auto-repeat FSM (PB0 only, see Configuration):**
  - States: RELEASED, HOLD, REPEAT.
  - RELEASED→HOLD on the PB0 press event. The repeat counter clears.
  - HOLD: the counter increments each cycle. At `REPEAT_DELAY_CYCLES` it generates a repeat event, clears the counter, and goes to REPEAT.
  - REPEAT: at `REPEAT_RATE_CYCLES` it generates a repeat event and clears the counter.
  - HOLD/REPEAT→RELEASED when `pb0_level = 0`, taking priority over a coincident repeat event. The counter clears.
  - A repeat event is treated exactly like a press event for flag and drop logic.
- **Buttons are independent:** simultaneous PB0/PB1 events set both flags. Prioritization is the timer's job (PB0 first).

## Timing
- **Reset values:** all flops 0. Outputs: `PB0_flag = PB1_flag = 0`, `pb0_level = pb1_level = 0`, `event_drop = 0`. Auto-repeat FSM = RELEASED.
- **Press latency:** take edge 0 as the first edge at which sync stage 1 captures the pressed level.
  - `levelx` rises at edge `1+DEBOUNCE_CYCLES`.
  - `PBx_flag` rises at edge `2+DEBOUNCE_CYCLES`.
- **Release latency:** `levelx` falls at edge `1+DEBOUNCE_CYCLES` after stage-1 capture of the released level.
- **Glitches:** a bounce shorter than `DEBOUNCE_CYCLES` stable cycles never changes `level`.
- **Consume:**
  - `PBx_read` high at edge n gives `PBx_flag = 0` after edge n.
  - The timer must not expect the flag to drop combinationally.
- **Repeat timing:** with PB0 held, the first repeat event fires `REPEAT_DELAY_CYCLES` cycles after the press event. Subsequent events fire every `REPEAT_RATE_CYCLES` cycles.
- **Reset mid-operation:** everything returns to reset values immediately. A button held across reset release is re-debounced and produces a fresh press event.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- Macro: `PB_AUTOREPEAT_EN`.
- **Defined:** the PB0 auto-repeat FSM and counter are present, as described above.
- **Undefined:** the FSM, counter, and `REPEAT_*` logic are absent. PB0 produces exactly one event per accepted press, like PB1. The parameters remain declared but are unused.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`, `REPEAT_DELAY_CYCLES = 20`, `REPEAT_RATE_CYCLES = 8`.
- **Clean press:** drive `PB0_n` low at cycle 0 and hold. `pb0_level` rises at edge 5 and `PB0_flag` at edge 6. With `PB0_read` pulsed at edge 10, the flag is 0 after edge 10.
- **Bounce:** toggle `PB1_n` low/high every 2 cycles for 20 cycles, then hold low. No flag during toggling. `PB1_flag` rises at edge 6 after the final stable low is captured.
- **Coincident event and read:** hold `PB0_flag = 1`, then pulse `PB0_read` on the same edge as a new press event. The flag stays 1 and `event_drop[0] = 0`.
- **Overrun:** press, release, then press PB1 again with no read. The second event gives `event_drop[1]` = one-cycle pulse and `PB1_flag` remains 1.
- **Auto-repeat (macro defined):** hold PB0 for 60 cycles and read each flag the cycle it appears. Flags appear at the press event and at +20, +28, +36, +44, +52. After release, no further flags. With the macro undefined, there is exactly one flag.
- **Reset mid-hold:** assert `rst_n = 0` during REPEAT. All outputs are 0 immediately. Release reset with PB0 still held: a new press event occurs at edge 6 after stage-1 capture.
